// File: rtl/traffic_demand_encoder_pkg.sv
// Shared constants and types for the traffic demand encoder.
package traffic_pkg;

  // Demand codes presented to TrafficController; 2'b11 is never driven.
  localparam logic [1:0] INDATA_NONE = 2'b00;
  localparam logic [1:0] INDATA_NS   = 2'b01;
  localparam logic [1:0] INDATA_EW   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_NS = 2'd1,
    ST_REQ_EW = 2'd2
  } state_e;

  // Lane most recently served; used to break ties between simultaneous requests.
  typedef enum logic {
    LANE_NS = 1'b0,
    LANE_EW = 1'b1
  } lane_e;

endpackage

// File: rtl/traffic_demand_encoder_if.sv
// Sensor, green-feedback and demand signals between the encoder and its environment.
interface traffic_demand_encoder_if;
  logic       ns_sensor_raw;
  logic       ew_sensor_raw;
  logic       north_south_GREEN;
  logic       east_west_GREEN;
  logic [1:0] indata;
  logic       ns_pending;
  logic       ew_pending;
  logic       conflict_err;

  // Environment side: drives detectors and green feedback, observes demand.
  modport master (
    output ns_sensor_raw, ew_sensor_raw, north_south_GREEN, east_west_GREEN,
    input  indata, ns_pending, ew_pending, conflict_err
  );

  // Encoder side.
  modport slave (
    input  ns_sensor_raw, ew_sensor_raw, north_south_GREEN, east_west_GREEN,
    output indata, ns_pending, ew_pending, conflict_err
  );
endinterface

// File: rtl/traffic_demand_encoder_debounce.sv
// Per-lane detector front end: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each debounced rising edge.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the asynchronous detector input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching samples; flip the level once the mismatch has lasted long enough.
  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/traffic_demand_encoder.sv
// Demand encoder: debounces both detectors, latches per-lane requests, presents
// one request at a time on indata until that lane's GREEN comes back, and flags
// simultaneous greens.
module traffic_demand_encoder
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                     clka,
  input  logic                     reseta,
  traffic_demand_encoder_if.slave  bus
);

  logic   ns_level, ew_level;
  logic   ns_rise, ew_rise;
  logic   ns_pending_q, ns_pending_d;
  logic   ew_pending_q, ew_pending_d;
  logic   conflict_q, conflict_d;
  state_e state_q;
  lane_e  last_served_q;
  logic [1:0] indata_q;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ns_debounce (
    .clk     (clka),
    .rst_n   (reseta),
    .raw_i   (bus.ns_sensor_raw),
    .level_o (ns_level),
    .rise_o  (ns_rise)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ew_debounce (
    .clk     (clka),
    .rst_n   (reseta),
    .raw_i   (bus.ew_sensor_raw),
    .level_o (ew_level),
    .rise_o  (ew_rise)
  );

  // Pending flags set on a debounced rise; a green on the lane clears and also
  // swallows a same-cycle rise, since that lane is being served already.
  always_comb begin
    ns_pending_d = ns_pending_q | ns_rise;
    ew_pending_d = ew_pending_q | ew_rise;
    if (bus.north_south_GREEN) ns_pending_d = 1'b0;
    if (bus.east_west_GREEN)   ew_pending_d = 1'b0;
    conflict_d = conflict_q | (bus.north_south_GREEN & bus.east_west_GREEN);
  end

  // Pending and sticky conflict registers.
  always_ff @(posedge clka or negedge reseta) begin
    if (!reseta) begin
      ns_pending_q <= 1'b0;
      ew_pending_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      ns_pending_q <= ns_pending_d;
      ew_pending_q <= ew_pending_d;
      conflict_q   <= conflict_d;
    end
  end

  // Request FSM with registered demand code; every grant returns through IDLE.
  always_ff @(posedge clka or negedge reseta) begin
    if (!reseta) begin
      state_q       <= ST_IDLE;
      indata_q      <= INDATA_NONE;
      last_served_q <= LANE_EW;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ns_pending_q && (!ew_pending_q || last_served_q == LANE_EW)) begin
            state_q  <= ST_REQ_NS;
            indata_q <= INDATA_NS;
          end else if (ew_pending_q) begin
            state_q  <= ST_REQ_EW;
            indata_q <= INDATA_EW;
          end else begin
            indata_q <= INDATA_NONE;
          end
        end
        ST_REQ_NS: begin
          if (bus.north_south_GREEN) begin
            state_q       <= ST_IDLE;
            indata_q      <= INDATA_NONE;
            last_served_q <= LANE_NS;
          end
        end
        ST_REQ_EW: begin
          if (bus.east_west_GREEN) begin
            state_q       <= ST_IDLE;
            indata_q      <= INDATA_NONE;
            last_served_q <= LANE_EW;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          indata_q <= INDATA_NONE;
        end
      endcase
    end
  end

  assign bus.indata       = indata_q;
  assign bus.ns_pending   = ns_pending_q;
  assign bus.ew_pending   = ew_pending_q;
  assign bus.conflict_err = conflict_q;

  // Debounced levels are kept for visibility; only the rise pulses drive requests.
  logic unused_levels;
  assign unused_levels = ns_level ^ ew_level;

endmodule

// File: tb/tb_traffic_demand_encoder.sv
// Scoreboard bench: stimulus pushes each expected indata change (code + clka edge
// number) into a queue; a monitor pops and compares whenever indata changes.
module tb_traffic_demand_encoder;
  import traffic_pkg::*;

  typedef struct {
    logic [1:0] code;
    int         edge_n;
  } exp_t;

  logic clka = 1'b0;
  logic reseta = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [1:0] prev_indata = 2'b00;

  traffic_demand_encoder_if bus ();

  traffic_demand_encoder #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clka   (clka),
    .reseta (reseta),
    .bus    (bus)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_code(logic [1:0] code, int edge_n);
    exp_t item;
    item.code   = code;
    item.edge_n = edge_n;
    exp_q.push_back(item);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic goto_edge(int e);
    while (cyc < e) tick(1);
  endtask

  task automatic sample_at(int e);
    goto_edge(e);
    @(negedge clka);
  endtask

  // Monitor: every change on indata must match the head of the scoreboard.
  always @(negedge clka) begin
    exp_t item;
    if (bus.indata !== prev_indata) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_indata: got %b at edge %0d, no change expected", bus.indata, cyc);
      end else begin
        item = exp_q.pop_front();
        check("indata_code", 32'(bus.indata), 32'(item.code));
        check("indata_edge", cyc, item.edge_n);
      end
      prev_indata = bus.indata;
    end
  end

  // Tie: NS must win first (last served EW), then EW after NS is served.
  task automatic run_tie();
    int e0;
    e0 = cyc;
    bus.ns_sensor_raw = 1'b1;
    bus.ew_sensor_raw = 1'b1;
    expect_code(INDATA_NS, e0 + 8);
    sample_at(e0 + 9);
    check("tie_both_pending", {bus.ns_pending, bus.ew_pending}, 2'b11);
    goto_edge(e0 + 10);
    bus.north_south_GREEN = 1'b1;
    expect_code(INDATA_NONE, e0 + 11);
    expect_code(INDATA_EW, e0 + 12);
    tick(1);
    bus.north_south_GREEN = 1'b0;
    @(negedge clka);
    check("tie_ew_waits", {bus.ns_pending, bus.ew_pending}, 2'b01);
    goto_edge(e0 + 14);
    bus.east_west_GREEN = 1'b1;
    expect_code(INDATA_NONE, e0 + 15);
    tick(1);
    bus.east_west_GREEN = 1'b0;
    bus.ns_sensor_raw = 1'b0;
    bus.ew_sensor_raw = 1'b0;
    tick(12);
  endtask

  initial begin
    int e0;
    int r;
    bus.ns_sensor_raw     = 1'b1;
    bus.ew_sensor_raw     = 1'b1;
    bus.north_south_GREEN = 1'b0;
    bus.east_west_GREEN   = 1'b0;
    #1 reseta = 1'b0;

    // 1: reset held with detectors high.
    for (int i = 0; i < 4; i++) begin
      tick(2);
      @(negedge clka);
      check("reset_indata", 32'(bus.indata), 32'(INDATA_NONE));
      check("reset_pending", {bus.ns_pending, bus.ew_pending}, 2'b00);
      check("reset_conflict", bus.conflict_err, 1'b0);
    end
    bus.ns_sensor_raw = 1'b0;
    bus.ew_sensor_raw = 1'b0;
    tick(3);
    reseta = 1'b1;
    tick(2);

    // 2: NS request latency and hold until green.
    e0 = cyc;
    bus.ns_sensor_raw = 1'b1;
    expect_code(INDATA_NS, e0 + 8);
    sample_at(e0 + 6);
    check("ns_pending_early", bus.ns_pending, 1'b0);
    sample_at(e0 + 7);
    check("ns_pending_edge7", bus.ns_pending, 1'b1);
    sample_at(e0 + 11);
    check("ns_held", 32'(bus.indata), 32'(INDATA_NS));
    goto_edge(e0 + 12);
    bus.north_south_GREEN = 1'b1;
    expect_code(INDATA_NONE, e0 + 13);
    tick(1);
    bus.north_south_GREEN = 1'b0;
    @(negedge clka);
    check("ns_pending_cleared", bus.ns_pending, 1'b0);
    bus.ns_sensor_raw = 1'b0;
    tick(12);

    // 3: short EW glitches are rejected; a 4-cycle pulse makes one request.
    for (int len = 1; len <= 3; len++) begin
      bus.ew_sensor_raw = 1'b1;
      tick(len);
      bus.ew_sensor_raw = 1'b0;
      tick(10);
      check("glitch_no_pending", bus.ew_pending, 1'b0);
    end
    e0 = cyc;
    bus.ew_sensor_raw = 1'b1;
    tick(4);
    bus.ew_sensor_raw = 1'b0;
    expect_code(INDATA_EW, e0 + 8);
    sample_at(e0 + 7);
    check("pulse4_pending", bus.ew_pending, 1'b1);
    goto_edge(e0 + 10);
    bus.east_west_GREEN = 1'b1;
    expect_code(INDATA_NONE, e0 + 11);
    tick(1);
    bus.east_west_GREEN = 1'b0;
    tick(12);

    // 4: tie arbitration after a fresh reset, twice.
    reseta = 1'b0;
    tick(2);
    reseta = 1'b1;
    tick(2);
    run_tie();
    run_tie();

    // 5a: rise while the lane is green is dropped.
    e0 = cyc;
    bus.east_west_GREEN = 1'b1;
    bus.ew_sensor_raw   = 1'b1;
    sample_at(e0 + 7);
    check("green_drop_rise", bus.ew_pending, 1'b0);
    goto_edge(e0 + 10);
    bus.east_west_GREEN = 1'b0;
    bus.ew_sensor_raw   = 1'b0;
    tick(12);
    check("green_drop_after", bus.ew_pending, 1'b0);

    // 5b: green in the very cycle the pending flag would set.
    e0 = cyc;
    bus.ew_sensor_raw = 1'b1;
    goto_edge(e0 + 6);
    bus.east_west_GREEN = 1'b1;
    tick(1);
    bus.east_west_GREEN = 1'b0;
    @(negedge clka);
    check("clear_wins_set", bus.ew_pending, 1'b0);
    tick(3);
    check("clear_wins_stays", bus.ew_pending, 1'b0);
    bus.ew_sensor_raw = 1'b0;
    tick(12);

    // 6: sticky conflict, then asynchronous reset mid REQ_EW.
    check("conflict_before", bus.conflict_err, 1'b0);
    bus.north_south_GREEN = 1'b1;
    bus.east_west_GREEN   = 1'b1;
    tick(1);
    bus.north_south_GREEN = 1'b0;
    bus.east_west_GREEN   = 1'b0;
    @(negedge clka);
    check("conflict_set", bus.conflict_err, 1'b1);
    tick(5);
    check("conflict_sticky", bus.conflict_err, 1'b1);

    e0 = cyc;
    bus.ew_sensor_raw = 1'b1;
    expect_code(INDATA_EW, e0 + 8);
    goto_edge(e0 + 9);
    #1;
    reseta = 1'b0;
    expect_code(INDATA_NONE, e0 + 9);
    #1;
    check("async_reset_indata", 32'(bus.indata), 32'(INDATA_NONE));
    check("async_reset_conflict", bus.conflict_err, 1'b0);
    check("async_reset_pending", bus.ew_pending, 1'b0);
    tick(2);
    reseta = 1'b1;
    r = cyc;
    expect_code(INDATA_EW, r + 8);
    sample_at(r + 6);
    check("release_no_early", bus.ew_pending, 1'b0);
    sample_at(r + 7);
    check("release_one_edge", bus.ew_pending, 1'b1);
    goto_edge(r + 10);
    bus.east_west_GREEN = 1'b1;
    expect_code(INDATA_NONE, r + 11);
    tick(1);
    bus.east_west_GREEN = 1'b0;
    bus.ew_sensor_raw   = 1'b0;
    tick(12);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
